delta_weight_fetch_arbiter: RTL



---
 rtl/delta_wm_pkg.sv | 28 ++
 rtl/delta_rr_arbiter.sv | 27 ++
 rtl/delta_weight_fetch_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/delta_wm_pkg.sv
// Shared state encoding and sizing helpers for the Delta weight-fetch arbiter.
package delta_wm_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] S_ARB      = 3'd1;
    localparam logic [STATE_W-1:0] S_LD_DRAM  = 3'd2;
    localparam logic [STATE_W-1:0] S_ST_SRAM  = 3'd3;
    localparam logic [STATE_W-1:0] S_LD_SRAM  = 3'd4;
    localparam logic [STATE_W-1:0] S_ST_BUFF  = 3'd5;
    localparam logic [STATE_W-1:0] S_IDX_PLUS = 3'd6;

    // Byte stride of one weight block: every PU's slice for one ic tile.
    function automatic int unsigned blk_bytes(input int unsigned pu_num,
                                              input int unsigned ic_tile,
                                              input int unsigned weight_bytes);
        return pu_num * ic_tile * weight_bytes;
    endfunction

    // Number of tiles after rounding a dimension up to the tile size; zero counts as one tile.
    function automatic int unsigned ceil_tiles(input int unsigned value,
                                               input int unsigned tile);
        if (value == 0) return 1;
        return (value + tile - 1) / tile;
    endfunction

endpackage

// File: rtl/delta_rr_arbiter.sv
// Round-robin priority pick: first set request at or after ptr, wrapping.
module delta_rr_arbiter #(
    parameter  int PU_NUM = 4,
    localparam int PW     = $clog2(PU_NUM)
) (
    input  logic [PU_NUM-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [PU_NUM-1:0] grant_oh,
    output logic [PW-1:0]     grant_idx,
    output logic              valid
);

    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int i = 0; i < PU_NUM; i++) begin
            if (!valid && req[ptr + PW'(i)]) begin
                valid                  = 1'b1;
                grant_idx              = ptr + PW'(i);
                grant_oh[ptr + PW'(i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delta_weight_fetch_arbiter.sv
// Weight-fetch controller: round-robin weight-buffer queries, DRAM->SRAM fill on the first
// spatial tile of each block, (oc, ic, row, col) loop tracking. Macro DELTA_WM_PERF_CNT_EN adds perf counters.
module delta_weight_fetch_arbiter
    import delta_wm_pkg::*;
#(
    parameter  int PU_NUM       = 4,
    parameter  int IC_TILE      = 8,
    parameter  int OC_TILE      = 4,
    parameter  int OUT_W        = 8,
    parameter  int OUT_H        = 8,
    parameter  int WEIGHT_BYTES = 16,
    parameter  int MAX_OC       = 1024,
    parameter  int MAX_IC       = 1024,
    parameter  int MAX_FS       = 256,
    parameter  int ADDR_W       = 32,
    localparam int PW           = $clog2(PU_NUM),
    localparam int OC_W         = $clog2(MAX_OC),
    localparam int IC_W         = $clog2(MAX_IC),
    localparam int FS_W         = $clog2(MAX_FS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           finish_cycle,
    input  logic [OC_W-1:0]                oc_num,
    input  logic [IC_W-1:0]                ic_num,
    input  logic [FS_W-1:0]                orc_size,
    input  logic [ADDR_W-1:0]              weight_start_address,
    input  logic [PU_NUM-1:0]              wb_req,
    input  logic [PU_NUM-1:0][ADDR_W-1:0]  wb_addr,
    output logic [PU_NUM-1:0]              wb_ready,
    output logic [ADDR_W-1:0]              sram_addr,
    output logic                           sram_w_en,
    output logic                           sram_r_en,
    input  logic                           sram_d_ready,
    input  logic                           sram_w_done,
    output logic                           dram_read,
    output logic [ADDR_W-1:0]              dram_address,
    input  logic                           dram_data_ready,
    output logic                           busy,
    output logic                           layer_done,
    output logic [31:0]                    perf_dram_fetches,
    output logic [31:0]                    perf_sram_reads
);

    localparam int                IDX_W     = $clog2(MAX_OC + MAX_IC + MAX_FS) + 1;
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [ADDR_W-1:0] BLK       = ADDR_W'(blk_bytes(PU_NUM, IC_TILE, WEIGHT_BYTES));
    localparam logic [ADDR_W-1:0] PU_STRIDE = ADDR_W'(IC_TILE * WEIGHT_BYTES);

    logic [STATE_W-1:0] state, state_next;
    logic [PW-1:0]      rr_ptr, grant_idx_q, arb_idx;
    logic [PU_NUM-1:0]  grant_oh_q, arb_oh;
    logic               arb_valid;
    logic [IDX_W-1:0]   ic_blk, o_c, o_r, oc_blk;
    logic [IDX_W-1:0]   ic_tiles, col_tiles, row_tiles, oc_tiles;
    logic               ic_last, col_last, row_last, oc_last;
    logic [ADDR_W-1:0]  blk_base, addr_next, sram_addr_q, dram_addr_q;

    delta_rr_arbiter #(.PU_NUM(PU_NUM)) u_rr (
        .req       (wb_req),
        .ptr       (rr_ptr),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    assign oc_tiles  = IDX_W'(ceil_tiles(32'(oc_num), OC_TILE * PU_NUM));
    assign ic_tiles  = IDX_W'(ceil_tiles(32'(ic_num), IC_TILE));
    assign col_tiles = IDX_W'(ceil_tiles(32'(orc_size), OUT_W));
    assign row_tiles = IDX_W'(ceil_tiles(32'(orc_size), OUT_H));

    assign ic_last  = (ic_blk >= ic_tiles - IDX_ONE);
    assign col_last = (o_c >= col_tiles - IDX_ONE);
    assign row_last = (o_r >= row_tiles - IDX_ONE);
    assign oc_last  = (oc_blk >= oc_tiles - IDX_ONE);

    assign blk_base  = (ADDR_W'(oc_blk) * ADDR_W'(ic_tiles) + ADDR_W'(ic_blk)) * BLK;
    assign addr_next = wb_addr[arb_idx] + ADDR_W'(arb_idx) * PU_STRIDE + blk_base;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (start) state_next = S_ARB;
            // A pending request always wins over a simultaneous finish_cycle.
            S_ARB: begin
                if (arb_valid)
                    state_next = (o_r == '0 && o_c == '0) ? S_LD_DRAM : S_LD_SRAM;
                else if (finish_cycle)
                    state_next = S_IDX_PLUS;
            end
            S_LD_DRAM:  if (dram_data_ready) state_next = S_ST_SRAM;
            S_ST_SRAM:  if (sram_w_done) state_next = S_LD_SRAM;
            S_LD_SRAM:  if (sram_d_ready) state_next = S_ST_BUFF;
            S_ST_BUFF:  state_next = S_ARB;
            S_IDX_PLUS: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            sram_addr_q <= '0;
            dram_addr_q <= '0;
            ic_blk      <= '0;
            o_c         <= '0;
            o_r         <= '0;
            oc_blk      <= '0;
        end else begin
            state <= state_next;
            // Grant and addresses are frozen here and held through ST_BUFF.
            if (state == S_ARB && arb_valid) begin
                grant_idx_q <= arb_idx;
                grant_oh_q  <= arb_oh;
                sram_addr_q <= addr_next;
                dram_addr_q <= weight_start_address + addr_next;
            end
            if (state == S_ST_BUFF)
                rr_ptr <= grant_idx_q + PW'(1);
            if (state == S_IDX_PLUS) begin
                if (!ic_last) begin
                    ic_blk <= ic_blk + IDX_ONE;
                end else begin
                    ic_blk <= '0;
                    if (!col_last) begin
                        o_c <= o_c + IDX_ONE;
                    end else begin
                        o_c <= '0;
                        if (!row_last) begin
                            o_r <= o_r + IDX_ONE;
                        end else begin
                            o_r <= '0;
                            oc_blk <= oc_last ? '0 : oc_blk + IDX_ONE;
                        end
                    end
                end
            end
        end
    end

    assign busy         = (state != S_IDLE);
    assign dram_read    = (state == S_LD_DRAM);
    assign sram_w_en    = (state == S_ST_SRAM);
    assign sram_r_en    = (state == S_LD_SRAM);
    assign wb_ready     = (state == S_ST_BUFF) ? grant_oh_q : '0;
    assign layer_done   = (state == S_IDX_PLUS) && ic_last && col_last && row_last && oc_last;
    assign sram_addr    = sram_addr_q;
    assign dram_address = dram_addr_q;

`ifdef DELTA_WM_PERF_CNT_EN
    logic [31:0] dram_cnt, sram_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            dram_cnt <= '0;
            sram_cnt <= '0;
        end else begin
            if (state == S_LD_DRAM && dram_data_ready && dram_cnt != '1)
                dram_cnt <= dram_cnt + 32'd1;
            if (state == S_LD_SRAM && sram_d_ready && sram_cnt != '1)
                sram_cnt <= sram_cnt + 32'd1;
        end
    end

    assign perf_dram_fetches = dram_cnt;
    assign perf_sram_reads   = sram_cnt;
`else
    assign perf_dram_fetches = '0;
    assign perf_sram_reads   = '0;
`endif

endmodule
